chunked_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder with carry-in. Adds operands CHUNK bits per cycle, LSB slice first,
//  and holds the carry between slices in a register.

---
 rtl/adder_pkg.sv | 13 +
 rtl/chunked_serial_adder_if.sv | 30 +++
 rtl/chunk_adder.sv | 31 +++
 rtl/chunked_serial_adder.sv | 127 ++++++++++++
 tb/tb_chunked_serial_adder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
//   add_state_t : control FSM states (IDLE -> RUN -> DONE -> IDLE)
//   idx_width() : width of the slice index register, never below 1 bit
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t;

  // $clog2(1) is 0, which would give a zero-width index for a single slice.
  function automatic int idx_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Handshake bundle of the chunked serial adder.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, overflow)
//   busy                : adder is working on or holding a result
// master = producer/consumer side, slave = the adder itself.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow, busy
  );
endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder used for one slice per cycle.
//   a, b  : slice operands
//   ci    : carry into bit 0 of the slice
//   s     : slice sum
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (needed for signed overflow)
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  always_comb begin
    logic c;
    c     = ci;
    s     = '0;
    c_msb = ci;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder with carry-in, CHUNK bits per cycle, LSB slice first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of chunked_serial_adder_if (operand and result handshakes)
// One operation in flight: IDLE accepts operands, RUN adds one slice per cycle,
// DONE presents the result until the consumer takes it.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  chunked_serial_adder_if.slave bus
);

  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0]  IDX_LAST   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("chunked_serial_adder: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
  end

  add_state_t       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [IDXW-1:0]  idx;
  logic [31:0]      off;

  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic [CHUNK-1:0] sl_s;
  logic             sl_co;
  logic             sl_cmsb;

  // Slice selection by shifting keeps the index arithmetic width-agnostic,
  // including the single-slice case.
  assign off  = 32'(idx) * 32'(CHUNK);
  assign sl_a = CHUNK'(a_r >> off);
  assign sl_b = CHUNK'(b_r >> off);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (sl_a),
    .b     (sl_b),
    .ci    (carry),
    .s     (sl_s),
    .co    (sl_co),
    .c_msb (sl_cmsb)
  );

  // Operands are captured only on accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_r <= bus.a;
      b_r <= bus.b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      carry       <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            carry      <= bus.cin;
            idx        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_r <= (sum_r & ~(SLICE_MASK << off)) | (WIDTH'(sl_s) << off);
          carry <= sl_co;
          if (idx == IDX_LAST) begin
            // Signed overflow: carry into the word MSB differs from carry out.
            cout_r      <= sl_co;
            ovf_r       <= sl_co ^ sl_cmsb;
            idx         <= '0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder.
// Main instance WIDTH=32/CHUNK=8; side instances WIDTH=1/CHUNK=1, WIDTH=4/CHUNK=1
// and WIDTH=32/CHUNK=32 share a small selectable stimulus path.
module tb_chunked_serial_adder;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  chunked_serial_adder_if #(.WIDTH(32)) bus     ();
  chunked_serial_adder_if #(.WIDTH(1))  bus_w1  ();
  chunked_serial_adder_if #(.WIDTH(4))  bus_w4  ();
  chunked_serial_adder_if #(.WIDTH(32)) bus_w32 ();

  chunked_serial_adder #(.WIDTH(32), .CHUNK(8))  u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  chunked_serial_adder #(.WIDTH(1),  .CHUNK(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(bus_w1));
  chunked_serial_adder #(.WIDTH(4),  .CHUNK(1))  u_w4  (.clk(clk), .rst_n(rst_n), .bus(bus_w4));
  chunked_serial_adder #(.WIDTH(32), .CHUNK(32)) u_w32 (.clk(clk), .rst_n(rst_n), .bus(bus_w32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the side instances, steered by sel (1, 4 or 32).
  int          sel;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        s_cin;
  logic        s_valid;

  assign bus_w1.in_valid  = s_valid && (sel == 1);
  assign bus_w1.a         = s_a[0:0];
  assign bus_w1.b         = s_b[0:0];
  assign bus_w1.cin       = s_cin;
  assign bus_w1.out_ready = 1'b1;
  assign bus_w4.in_valid  = s_valid && (sel == 4);
  assign bus_w4.a         = s_a[3:0];
  assign bus_w4.b         = s_b[3:0];
  assign bus_w4.cin       = s_cin;
  assign bus_w4.out_ready = 1'b1;
  assign bus_w32.in_valid  = s_valid && (sel == 32);
  assign bus_w32.a         = s_a;
  assign bus_w32.b         = s_b;
  assign bus_w32.cin       = s_cin;
  assign bus_w32.out_ready = 1'b1;

  logic        o_valid, o_ready, o_busy, o_cout, o_ovf;
  logic [31:0] o_sum;
  assign o_valid = (sel == 1) ? bus_w1.out_valid : (sel == 4) ? bus_w4.out_valid : bus_w32.out_valid;
  assign o_ready = (sel == 1) ? bus_w1.in_ready  : (sel == 4) ? bus_w4.in_ready  : bus_w32.in_ready;
  assign o_busy  = (sel == 1) ? bus_w1.busy      : (sel == 4) ? bus_w4.busy      : bus_w32.busy;
  assign o_cout  = (sel == 1) ? bus_w1.cout      : (sel == 4) ? bus_w4.cout      : bus_w32.cout;
  assign o_ovf   = (sel == 1) ? bus_w1.overflow  : (sel == 4) ? bus_w4.overflow  : bus_w32.overflow;
  assign o_sum   = (sel == 1) ? 32'(bus_w1.sum)  : (sel == 4) ? 32'(bus_w4.sum)  : bus_w32.sum;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, cout, sum} of a w-bit add, signed range checked in 64-bit math.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    longint mask, ua, ub, full, sa, sb, ss, half;
    logic   ovf;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    full = ua + ub + longint'(cin);
    sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
    ss   = sa + sb + longint'(cin);
    ovf  = (ss > half - 1) || (ss < -half);
    return {ovf, 1'(full >> w), 32'(full & mask)};
  endfunction

  task automatic op_main(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input int stall, input bit poke, input string tag);
    int n;
    @(posedge clk); #1;
    chk({tag, "_in_ready_idle"}, bus.in_ready, 1'b1);
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.cin = ~cin;
    chk({tag, "_busy_run"}, bus.busy, 1'b1);
    chk({tag, "_in_ready_run"}, bus.in_ready, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd4);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
    chk({tag, "_ovf"}, bus.overflow, eo);
    for (int k = 0; k < stall; k++) begin
      if (poke) begin
        bus.in_valid = 1'b1; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
      end
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_hold_in_ready"}, bus.in_ready, 1'b0);
      chk({tag, "_hold_sum"}, bus.sum, es);
      chk({tag, "_hold_flags"}, {bus.cout, bus.overflow}, {ec, eo});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_done_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_done_in_ready"}, bus.in_ready, 1'b1);
    chk({tag, "_done_busy"}, bus.busy, 1'b0);
  endtask

  task automatic op_small(input int w, input int lat, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] es, input logic ec, input logic eo,
                          input string tag);
    int n;
    sel = w;
    @(posedge clk); #1;
    chk({tag, "_in_ready_idle"}, o_ready, 1'b1);
    s_a = a; s_b = b; s_cin = cin; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_a = ~a; s_b = ~b;
    chk({tag, "_busy"}, o_busy || o_valid, 1'b1);
    n = 0;
    while (!o_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_sum"}, o_sum, es);
    chk({tag, "_cout"}, o_cout, ec);
    chk({tag, "_ovf"}, o_ovf, eo);
    @(posedge clk); #1;
    chk({tag, "_done_valid"}, o_valid, 1'b0);
  endtask

  initial begin
    logic [33:0] e;
    logic [31:0] ra, rb;
    logic        rc;
    errors = 0; checks = 0;
    sel = 0; s_a = '0; s_b = '0; s_cin = 1'b0; s_valid = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_outputs", {bus.sum, bus.cout, bus.overflow}, 34'd0);
    @(negedge clk) rst_n = 1'b1;

    // Carry ripple, signed overflow, mixed-sign add
    op_main(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0, "ripple");
    op_main(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0, "ovf_pos");
    op_main(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0, 1'b0, "ovf_neg");
    op_main(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 0, 1'b0, "mixed");

    // Backpressure with an ignored second request, then the real second pair
    op_main(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 5, 1'b1, "bp_first");
    op_main(32'hFFFF_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 0, 1'b0, "bp_second");

    // Reset mid-RUN after two slices
    @(posedge clk); #1;
    bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("midrun_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_in_ready", bus.in_ready, 1'b1);
    chk("midrun_rst_out_valid", bus.out_valid, 1'b0);
    chk("midrun_rst_busy", bus.busy, 1'b0);
    chk("midrun_rst_outputs", {bus.sum, bus.cout, bus.overflow}, 34'd0);
    #2 rst_n = 1'b1;
    op_main(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0, "after_rst");

    // Config sweep
    for (int v = 0; v < 8; v++) begin
      ra = 32'(v >> 2); rb = 32'((v >> 1) & 1); rc = 1'(v);
      e  = model(1, ra, rb, rc);
      op_small(1, 1, ra, rb, rc, e[31:0], e[32], e[33], $sformatf("w1_fa%0d", v));
    end
    op_small(4, 4, 32'hF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, "w4_wrap");
    op_small(4, 4, 32'h7, 32'h0, 1'b1, 32'h8, 1'b0, 1'b1, "w4_ovf");
    op_small(4, 4, 32'h9, 32'h6, 1'b1, 32'h0, 1'b1, 1'b0, "w4_mix");
    op_small(32, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "w32_full");
    op_small(32, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, "w32_ovf");

    // Random operations with random result stalls
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (i % 16 == 0) ra = 32'hFFFF_FFFF;
      if (i % 16 == 1) begin ra = 32'h7FFF_FFFF; rb = 32'(i); end
      e = model(32, ra, rb, rc);
      op_main(ra, rb, rc, e[31:0], e[32], e[33], $urandom_range(0, 3), 1'b0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
